// File: rtl/regfile_sb_if.sv
// regfile_sb_if: issue handshake between decode and the register scoreboard.
// Ports: issue_valid/issue_rd from decode (master), issue_ready back (slave).
interface regfile_sb_if #(
    parameter int AW = 5
);
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_ready;

    modport master (
        output issue_valid,
        output issue_rd,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_rd,
        output issue_ready
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two write ports, write bypass on
// every read port, and a scoreboard of pending long-latency destinations.
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   rs_addr/rs_data   NRP packed read ports (combinational, bypassed)
//   rs_busy           per read port: register awaits a long-latency write
//   wr0_*             single-cycle writeback port (wins on collision)
//   wr1_*             long-latency writeback port, retires scoreboard entry
//   iss               issue handshake (valid/rd in, ready out)
//   pending_cnt       number of pending registers
//   wr_conflict       sticky: both write ports hit the same nonzero register
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_data,
    output logic [NRP-1:0]      rs_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    regfile_sb_if.slave         iss,
    output logic [AW:0]         pending_cnt,
    output logic                wr_conflict
);

    localparam int NREG = 2 ** AW;

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    logic wr0_hit;
    logic wr1_hit;
    logic collide;
    logic wr1_retires_rd;
    logic accept;
    logic set_hit;
    logic inc;
    logic dec;

    // ---------------------------------------------------------------
    // Write-port qualification
    // ---------------------------------------------------------------
    assign wr0_hit = wr0_en && (wr0_addr != '0);
    assign wr1_hit = wr1_en && (wr1_addr != '0);
    assign collide = wr0_hit && wr1_hit && (wr0_addr == wr1_addr);

    // ---------------------------------------------------------------
    // Issue handshake
    // ---------------------------------------------------------------
    // A pending destination may be reissued in the same cycle its
    // long-latency result retires; the new claim then takes over.
    assign wr1_retires_rd = wr1_en && (wr1_addr == iss.issue_rd);

    assign iss.issue_ready = (iss.issue_rd == '0)
                           || !pending[iss.issue_rd]
                           || wr1_retires_rd;

    assign accept  = iss.issue_valid && iss.issue_ready;
    assign set_hit = accept && (iss.issue_rd != '0);

    // ---------------------------------------------------------------
    // Scoreboard next state
    // ---------------------------------------------------------------
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_hit) begin
            set_vec[iss.issue_rd] = 1'b1;
        end
        if (wr1_hit) begin
            clr_vec[wr1_addr] = 1'b1;
        end
        // Set is applied after clear so a same-cycle reissue survives.
        pending_nxt    = (pending & ~clr_vec) | set_vec;
        pending_nxt[0] = 1'b0;
    end

    // Count only real 0->1 and 1->0 transitions of the pending vector.
    assign inc = set_hit && !pending[iss.issue_rd];
    assign dec = wr1_hit && pending[wr1_addr]
              && !(set_hit && (iss.issue_rd == wr1_addr));

    // ---------------------------------------------------------------
    // Sequential state
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= '0;
            pending_cnt <= '0;
            wr_conflict <= 1'b0;
        end else begin
            pending <= pending_nxt;
            unique case ({inc, dec})
                2'b10:   pending_cnt <= pending_cnt + 1'b1;
                2'b01:   pending_cnt <= pending_cnt - 1'b1;
                default: pending_cnt <= pending_cnt;
            endcase
            if (collide) begin
                wr_conflict <= 1'b1;
            end
        end
    end

    // wr0 is written last so it wins when both ports hit one register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (wr1_hit) begin
                mem[wr1_addr] <= wr1_data;
            end
            if (wr0_hit) begin
                mem[wr0_addr] <= wr0_data;
            end
        end
    end

    // ---------------------------------------------------------------
    // Read ports with write bypass
    // ---------------------------------------------------------------
    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            wr1_match;

        assign a         = rs_addr[i*AW +: AW];
        assign wr1_match = wr1_en && (wr1_addr == a);

        always_comb begin
            if (a == '0) begin
                d = '0;
            end else if (wr0_en && (wr0_addr == a)) begin
                d = wr0_data;
            end else if (wr1_match) begin
                d = wr1_data;
            end else begin
                d = mem[a];
            end
        end

        assign rs_data[i*XLEN +: XLEN] = d;
        assign rs_busy[i] = pending[a] && !wr1_match;
    end

endmodule
